mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 34 +++
 rtl/mem_wb_stage.sv | 81 ++++++++
 tb/tb_mem_wb_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bundle: MEM-side instruction, memory data,
// hazard controls and the writeback/bypass results.
interface mem_wb_stage_if;
  logic        valid_in;
  logic        RegW_in;
  logic        MemR_in;
  logic [2:0]  Rd_in;
  logic [15:0] ALUResult_in;
  logic [15:0] MemoryOut;
  logic        stall;
  logic        flush;
  logic        RegWrite;
  logic [2:0]  WriteReg;
  logic [15:0] WriteData;
  logic        fwd_valid;
  logic [2:0]  fwd_reg;
  logic [15:0] fwd_data;

  modport master (
    output valid_in, RegW_in, MemR_in,
    output Rd_in, ALUResult_in, MemoryOut,
    output stall, flush,
    input  RegWrite, WriteReg, WriteData,
    input  fwd_valid, fwd_reg, fwd_data
  );

  modport slave (
    input  valid_in, RegW_in, MemR_in,
    input  Rd_in, ALUResult_in, MemoryOut,
    input  stall, flush,
    output RegWrite, WriteReg, WriteData,
    output fwd_valid, fwd_reg, fwd_data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Writeback stage with stalled-load data hold and bypass.
// MEM_WB_PERF_CNT_EN adds the 16-bit retired counter.
module mem_wb_stage (
  input  logic         clk,
  input  logic         reset_n,
`ifdef MEM_WB_PERF_CNT_EN
  output logic [15:0]  retired,
`endif
  mem_wb_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        regw;
    logic        memr;
    logic [2:0]  rd;
    logic [15:0] alu;
  } wb_t;

  wb_t         wb_q;
  logic        ld_held;
  logic [15:0] hold_q;
  logic [15:0] ld_data;
  logic        wr_en;
  logic [15:0] wr_data;

  // Memory data is only valid one cycle; park it once a stall hits.
  assign ld_data = ld_held ? hold_q : bus.MemoryOut;
  assign wr_data = wb_q.memr ? ld_data : wb_q.alu;
  assign wr_en   = wb_q.valid & wb_q.regw & ~bus.stall;

  assign bus.RegWrite  = wr_en;
  assign bus.WriteReg  = wb_q.rd;
  assign bus.WriteData = wr_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_q    <= '0;
      ld_held <= 1'b0;
      hold_q  <= '0;
    end else if (!bus.stall) begin
      ld_held <= 1'b0;
      if (bus.flush) begin
        wb_q.valid <= 1'b0;
        wb_q.regw  <= 1'b0;
        wb_q.memr  <= 1'b0;
      end else begin
        wb_q.valid <= bus.valid_in;
        wb_q.regw  <= bus.RegW_in;
        wb_q.memr  <= bus.MemR_in;
        wb_q.rd    <= bus.Rd_in;
        wb_q.alu   <= bus.ALUResult_in;
      end
    end else if (wb_q.valid && wb_q.memr && !ld_held) begin
      hold_q  <= bus.MemoryOut;
      ld_held <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.fwd_valid <= 1'b0;
      bus.fwd_reg   <= '0;
      bus.fwd_data  <= '0;
    end else if (wr_en) begin
      bus.fwd_valid <= 1'b1;
      bus.fwd_reg   <= wb_q.rd;
      bus.fwd_data  <= wr_data;
    end
  end

`ifdef MEM_WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      retired <= '0;
    else if (wb_q.valid && !bus.stall)
      retired <= retired + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected writes queued
// at issue, popped when RegWrite is seen.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic reset_n;
`ifdef MEM_WB_PERF_CNT_EN
  logic [15:0] retired;
`endif

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef MEM_WB_PERF_CNT_EN
    .retired (retired),
`endif
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_pass = 0;
  int  n_tot  = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic regw, input logic memr,
                       input logic [2:0] rd,
                       input logic [15:0] alu);
    bus.valid_in     = 1'b1;
    bus.RegW_in      = regw;
    bus.MemR_in      = memr;
    bus.Rd_in        = rd;
    bus.ALUResult_in = alu;
  endtask

  task automatic idle();
    bus.valid_in = 1'b0;
    bus.RegW_in  = 1'b0;
    bus.MemR_in  = 1'b0;
  endtask

  task automatic push(input logic [2:0] r,
                      input logic [15:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_wr", 32'(bus.WriteReg), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("sb_reg", 32'(bus.WriteReg), 32'(e.r));
        check("sb_data", 32'(bus.WriteData), 32'(e.d));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    idle();
    bus.Rd_in        = '0;
    bus.ALUResult_in = '0;
    bus.MemoryOut    = '0;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    tick();
    bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    reset_n   = 1'b1;
    check("rst_regwrite", 32'(bus.RegWrite), 0);
    check("rst_writereg", 32'(bus.WriteReg), 0);
    check("rst_writedata", 32'(bus.WriteData), 0);
    check("rst_fwd_valid", 32'(bus.fwd_valid), 0);

    // ALU op
    issue(1'b1, 1'b0, 3'd3, 16'h1234);
    push(3'd3, 16'h1234);
    tick();
    idle();
    #1;
    check("alu_regwrite", 32'(bus.RegWrite), 1);
    check("alu_data", 32'(bus.WriteData), 32'h1234);
    tick();
    check("alu_fwd_valid", 32'(bus.fwd_valid), 1);
    check("alu_fwd_reg", 32'(bus.fwd_reg), 3);
    check("alu_fwd_data", 32'(bus.fwd_data), 32'h1234);
    check("alu_one_wr", 32'(bus.RegWrite), 0);

    // Load, no stall
    issue(1'b1, 1'b1, 3'd5, 16'h0002);
    push(3'd5, 16'h3333);
    tick();
    idle();
    bus.MemoryOut = 16'h3333;
    #1;
    check("ld_regwrite", 32'(bus.RegWrite), 1);
    check("ld_data", 32'(bus.WriteData), 32'h3333);
    tick();

    // Stalled load
    issue(1'b1, 1'b1, 3'd6, 16'h0004);
    push(3'd6, 16'h3333);
    bus.MemoryOut = 16'h0000;
    tick();
    idle();
    bus.MemoryOut = 16'h3333;
    bus.stall     = 1'b1;
    #1;
    check("stl_no_wr0", 32'(bus.RegWrite), 0);
    tick();
    bus.MemoryOut = 16'hBEEF;
    #1;
    check("stl_no_wr1", 32'(bus.RegWrite), 0);
    check("stl_hold", 32'(bus.WriteData), 32'h3333);
    tick();
    tick();
    bus.stall = 1'b0;
    #1;
    check("stl_rel_wr", 32'(bus.RegWrite), 1);
    check("stl_rel_data", 32'(bus.WriteData), 32'h3333);
    tick();
    check("stl_once", 32'(bus.RegWrite), 0);
    check("stl_fwd_data", 32'(bus.fwd_data), 32'h3333);

    // Flush kills the entering instruction
    issue(1'b1, 1'b0, 3'd7, 16'hAAAA);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    #1;
    check("fl_no_wr", 32'(bus.RegWrite), 0);
    check("fl_fwd_reg", 32'(bus.fwd_reg), 6);
    check("fl_fwd_data", 32'(bus.fwd_data), 32'h3333);
    tick();

    // Stall overrides flush
    issue(1'b1, 1'b0, 3'd1, 16'h5555);
    push(3'd1, 16'h5555);
    tick();
    issue(1'b1, 1'b0, 3'd2, 16'h6666);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    check("sf_no_wr", 32'(bus.RegWrite), 0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    idle();
    #1;
    check("sf_wr", 32'(bus.RegWrite), 1);
    check("sf_reg", 32'(bus.WriteReg), 1);
    check("sf_data", 32'(bus.WriteData), 32'h5555);
    tick();

    // Rd=0 is an ordinary register
    issue(1'b1, 1'b0, 3'd0, 16'h0F0F);
    push(3'd0, 16'h0F0F);
    tick();
    idle();
    #1;
    check("r0_wr", 32'(bus.RegWrite), 1);
    check("r0_data", 32'(bus.WriteData), 32'h0F0F);
    tick();

    // Reset during a stalled load
    issue(1'b1, 1'b1, 3'd4, 16'h0008);
    tick();
    idle();
    bus.MemoryOut = 16'h9999;
    bus.stall     = 1'b1;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("rs_no_wr", 32'(bus.RegWrite), 0);
    check("rs_data", 32'(bus.WriteData), 0);
    check("rs_fwd_valid", 32'(bus.fwd_valid), 0);
    bus.stall = 1'b0;
    #1;
    check("rs_rel_no_wr", 32'(bus.RegWrite), 0);
    tick();
    tick();
    check("rs_still_none", 32'(bus.fwd_valid), 0);

`ifdef MEM_WB_PERF_CNT_EN
    check("cnt_rst", 32'(retired), 0);
    issue(1'b0, 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 65535; i++) tick();
    idle();
    tick();
    check("cnt_ffff", 32'(retired), 32'hFFFF);
    issue(1'b0, 1'b0, 3'd2, 16'h0010);
    tick();
    idle();
    bus.stall = 1'b1;
    tick();
    check("cnt_stall", 32'(retired), 32'hFFFF);
    bus.stall = 1'b0;
    tick();
    check("cnt_wrap", 32'(retired), 0);
`endif

    tick();
    check("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
